cache_fill_arbiter: RTL and testbench
=====================================

CACHE_FILL_ARBITER -- requirements
Module: cache_fill_arbiter

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 i_miss  in  1  I-cache miss pending.
REQ-004 i_addr  in  16  I-cache miss byte address.
REQ-005 d_miss  in  1  D-cache load miss pending.
REQ-006 d_addr  in  16  D-cache miss or store byte address.
REQ-007 d_wr_req  in  1  D-side write-through store request.
REQ-008 d_wr_data  in  16  store data.
REQ-009 mem_data_in  in  16  memory read data.
REQ-010 mem_data_valid  in  1  mem_data_in valid; returns exactly 4 cycles after each read issue.
REQ-011 mem_en  out  1  memory access this cycle.
REQ-012 mem_wr  out  1  access is a write.
REQ-013 mem_addr  out  16  memory byte address.
REQ-014 mem_data_out  out  16  memory write data.
REQ-015 fill_data  out  16  word to write into the cache being filled.
REQ-016 fill_addr  out  16  cache byte address for fill_data.
REQ-017 i_fill_data_en, d_fill_data_en  out  1 each  cache data-array write strobe.
REQ-018 i_fill_tag_en, d_fill_tag_en  out  1 each  cache meta-array (tag/valid/LRU) write strobe.
REQ-019 d_wr_ack  out  1  store accepted this cycle.
REQ-020 busy  out  1  state != IDLE.

Function
REQ-021 States SHALL be IDLE, WRITE, FILL_I, FILL_D; 4-bit issue counter icnt, 4-bit receive counter rcnt, 16-bit base register.
REQ-022 In IDLE the arbiter SHALL accept the highest-priority request: d_wr_req > d_miss > i_miss; fixed priority, no round-robin.
REQ-023 d_wr_req in IDLE -> WRITE next cycle; in WRITE: mem_en=1, mem_wr=1, mem_addr=d_addr, mem_data_out=d_wr_data, d_wr_ack=1; then IDLE.
REQ-024 Miss accepted in IDLE -> base = addr & 16'hFFF0, icnt=rcnt=0, next state FILL_D or FILL_I.
REQ-025 In FILL_*: while icnt<8, mem_en=1, mem_wr=0, mem_addr=base+2*icnt, icnt++ each cycle; icnt saturates at 8 (no further issue).
REQ-026 In FILL_*, on mem_data_valid: fill_data=mem_data_in, fill_addr=base+2*rcnt, target *_fill_data_en=1, rcnt++.
REQ-027 When mem_data_valid with rcnt==7: target *_fill_tag_en=1 in the same cycle, fill_addr=base+14, next state IDLE.
REQ-028 Timing: miss accepted cycle t -> issues t+1..t+8, data t+5..t+12, tag write t+12, IDLE t+13; a new request may be accepted at t+13.
REQ-029 Only the target cache's strobes SHALL assert; the other cache's strobes stay 0.
REQ-030 Requests arriving in non-IDLE states SHALL be held off (not latched); requester keeps its request high until serviced.
REQ-031 mem_data_valid in IDLE or WRITE SHALL be ignored (no strobes, no state change).
REQ-032 Address arithmetic 16-bit modulo; base+14 never crosses the 16-byte block.
REQ-033 When mem_en=0, mem_addr, mem_data_out SHALL be 0; fill_data, fill_addr SHALL be 0 when no fill strobe asserts.

Reset
REQ-034 rst SHALL force IDLE, icnt=rcnt=0, base=0; all outputs 0 in the cycle after rst is sampled.
REQ-035 rst mid-fill SHALL abandon the fill; later in-flight mem_data_valid ignored per REQ-031; no tag write occurs.

Verification
REQ-036 i_miss, i_addr=16'h1234 at t -> mem reads 16'h1230..16'h123E t+1..t+8; i_fill_data_en t+5..t+12 with fill_addr 16'h1230..16'h123E; i_fill_tag_en at t+12 only; busy low t+13.
REQ-037 d_miss and i_miss both high at t -> FILL_D serviced first (d_addr block); FILL_I accepted at t+13, first I issue t+14.
REQ-038 d_wr_req, d_miss, i_miss all high in IDLE -> WRITE with d_wr_ack=1, mem_wr=1, mem_addr=d_addr, mem_data_out=d_wr_data; then FILL_D.
REQ-039 d_wr_req raised during FILL_I -> no d_wr_ack until fill completes; WRITE occurs the cycle after return to IDLE.
REQ-040 rst asserted at t+7 of a fill -> busy=0, no strobes at t+8..t+12 despite mem_data_valid; next i_miss restarts full 8-word fill.
REQ-041 mem_data_valid pulsed in IDLE with mem_data_in=16'hBEEF -> no fill strobes, state stays IDLE.

Source files
------------

// File: rtl/cache_fill_arbiter.sv
// ---------------------------------------------------------------------------
// cache_fill_arbiter
//
// Purpose:
//   Shares a single memory port between an I-cache and a D-cache. Three kinds
//   of request compete for the port, in fixed priority order:
//     1. D-side write-through store (single-cycle write)
//     2. D-cache load miss          (8-word block fill)
//     3. I-cache miss               (8-word block fill)
//   A block fill issues eight pipelined word reads (one per cycle) and
//   forwards each returning word to the cache being filled. The last word
//   also strobes the cache's tag/valid/LRU array.
//
// Ports:
//   clk            in   system clock, rising-edge active
//   rst            in   synchronous active-high reset
//   i_miss         in   I-cache miss pending
//   i_addr[15:0]   in   I-cache miss byte address
//   d_miss         in   D-cache load miss pending
//   d_addr[15:0]   in   D-cache miss or store byte address
//   d_wr_req       in   D-side write-through store request
//   d_wr_data[15:0]in   store data
//   mem_data_in    in   memory read data
//   mem_data_valid in   read data valid, 4 cycles after each read issue
//   mem_en         out  memory access this cycle
//   mem_wr         out  access is a write
//   mem_addr       out  memory byte address (0 when idle)
//   mem_data_out   out  memory write data (0 when idle)
//   fill_data      out  word to write into the cache being filled
//   fill_addr      out  cache byte address for fill_data
//   i/d_fill_data_en out cache data-array write strobe
//   i/d_fill_tag_en  out cache meta-array write strobe
//   d_wr_ack       out  store accepted this cycle
//   busy           out  arbiter is not idle
// ---------------------------------------------------------------------------
module cache_fill_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_miss,
    input  logic [15:0] i_addr,
    input  logic        d_miss,
    input  logic [15:0] d_addr,
    input  logic        d_wr_req,
    input  logic [15:0] d_wr_data,
    input  logic [15:0] mem_data_in,
    input  logic        mem_data_valid,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data_out,
    output logic [15:0] fill_data,
    output logic [15:0] fill_addr,
    output logic        i_fill_data_en,
    output logic        d_fill_data_en,
    output logic        i_fill_tag_en,
    output logic        d_fill_tag_en,
    output logic        d_wr_ack,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        FILL_I = 2'd2,
        FILL_D = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  icnt_q, icnt_d;
    logic [3:0]  rcnt_q, rcnt_d;
    logic [15:0] base_q, base_d;

    logic        filling;
    logic        issuing;
    logic        receiving;
    logic        lastWord;
    logic [15:0] issueOffset;
    logic [15:0] recvOffset;

    // Decoded views of the registered state shared by next-state and output
    // logic. icnt bit 3 marks "all eight reads issued", so issue stops there.
    assign filling     = (state_q == FILL_I) || (state_q == FILL_D);
    assign issuing     = filling && !icnt_q[3];
    assign receiving   = filling && mem_data_valid;
    assign lastWord    = receiving && (rcnt_q == 4'd7);
    assign issueOffset = {12'd0, icnt_q[2:0], 1'b0};
    assign recvOffset  = {12'd0, rcnt_q[2:0], 1'b0};

    // Next-state logic. IDLE arbitrates with fixed priority; any request seen
    // in another state is simply not looked at, so the requester must hold it.
    // A fill ends on the eighth returned word, independent of the issue count.
    always_comb begin
        state_d = state_q;
        icnt_d  = icnt_q;
        rcnt_d  = rcnt_q;
        base_d  = base_q;
        case (state_q)
            IDLE: begin
                if (d_wr_req) begin
                    state_d = WRITE;
                end else if (d_miss) begin
                    state_d = FILL_D;
                    base_d  = d_addr & 16'hFFF0;
                    icnt_d  = 4'd0;
                    rcnt_d  = 4'd0;
                end else if (i_miss) begin
                    state_d = FILL_I;
                    base_d  = i_addr & 16'hFFF0;
                    icnt_d  = 4'd0;
                    rcnt_d  = 4'd0;
                end
            end
            WRITE: begin
                state_d = IDLE;
            end
            FILL_I, FILL_D: begin
                if (issuing) begin
                    icnt_d = icnt_q + 4'd1;
                end
                if (receiving) begin
                    rcnt_d = rcnt_q + 4'd1;
                    if (lastWord) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset. Resetting mid-fill drops the
    // fill; read data still in flight later arrives in IDLE and is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            icnt_q  <= 4'd0;
            rcnt_q  <= 4'd0;
            base_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            icnt_q  <= icnt_d;
            rcnt_q  <= rcnt_d;
            base_q  <= base_d;
        end
    end

    // Memory-side outputs. A store drives the D-side address and data
    // straight through in the WRITE cycle; fills issue base + 2*icnt.
    // Address and data are forced to zero whenever the port is unused.
    always_comb begin
        mem_en       = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = 16'd0;
        mem_data_out = 16'd0;
        d_wr_ack     = 1'b0;
        if (state_q == WRITE) begin
            mem_en       = 1'b1;
            mem_wr       = 1'b1;
            mem_addr     = d_addr;
            mem_data_out = d_wr_data;
            d_wr_ack     = 1'b1;
        end else if (issuing) begin
            mem_en   = 1'b1;
            mem_addr = base_q + issueOffset;
        end
    end

    // Cache-side outputs. Returning words are forwarded in the same cycle
    // they arrive; only the cache owning the current fill is strobed, and the
    // meta-array strobe rides with the eighth word at base + 14.
    always_comb begin
        fill_data      = 16'd0;
        fill_addr      = 16'd0;
        i_fill_data_en = 1'b0;
        d_fill_data_en = 1'b0;
        i_fill_tag_en  = 1'b0;
        d_fill_tag_en  = 1'b0;
        if (receiving) begin
            fill_data = mem_data_in;
            fill_addr = base_q + recvOffset;
            if (state_q == FILL_I) begin
                i_fill_data_en = 1'b1;
                i_fill_tag_en  = lastWord;
            end else begin
                d_fill_data_en = 1'b1;
                d_fill_tag_en  = lastWord;
            end
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cache_fill_arbiter
//
// Directed bench for cache_fill_arbiter. A small memory model returns each
// read 4 cycles after it is issued, with data = address ^ 16'hA5A5, and keeps
// returning in-flight reads across a reset. Inputs change #1 after the rising
// edge and outputs are compared on the falling edge.
// ---------------------------------------------------------------------------
module tb_cache_fill_arbiter;

    logic        clk;
    logic        rst;
    logic        i_miss;
    logic [15:0] i_addr;
    logic        d_miss;
    logic [15:0] d_addr;
    logic        d_wr_req;
    logic [15:0] d_wr_data;
    logic [15:0] mem_data_in;
    logic        mem_data_valid;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_data_out;
    logic [15:0] fill_data;
    logic [15:0] fill_addr;
    logic        i_fill_data_en;
    logic        d_fill_data_en;
    logic        i_fill_tag_en;
    logic        d_fill_tag_en;
    logic        d_wr_ack;
    logic        busy;

    int checkCount = 0;
    int failCount  = 0;
    int stepNo     = 0;

    logic        injValid = 1'b0;
    logic [15:0] injData  = 16'h0000;
    logic [3:0]  pipeV    = 4'b0000;
    logic [15:0] pipeA [4];

    cache_fill_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .i_miss         (i_miss),
        .i_addr         (i_addr),
        .d_miss         (d_miss),
        .d_addr         (d_addr),
        .d_wr_req       (d_wr_req),
        .d_wr_data      (d_wr_data),
        .mem_data_in    (mem_data_in),
        .mem_data_valid (mem_data_valid),
        .mem_en         (mem_en),
        .mem_wr         (mem_wr),
        .mem_addr       (mem_addr),
        .mem_data_out   (mem_data_out),
        .fill_data      (fill_data),
        .fill_addr      (fill_addr),
        .i_fill_data_en (i_fill_data_en),
        .d_fill_data_en (d_fill_data_en),
        .i_fill_tag_en  (i_fill_tag_en),
        .d_fill_tag_en  (d_fill_tag_en),
        .d_wr_ack       (d_wr_ack),
        .busy           (busy)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: a 4-stage read-return pipeline that is never reset, so
    // reads issued before a DUT reset still come back afterwards.
    always @(posedge clk) begin
        pipeV    <= {pipeV[2:0], mem_en & ~mem_wr};
        pipeA[0] <= mem_addr;
        pipeA[1] <= pipeA[0];
        pipeA[2] <= pipeA[1];
        pipeA[3] <= pipeA[2];
    end

    // Returned data, with an override used to inject a stray valid pulse.
    assign mem_data_valid = pipeV[3] | injValid;
    assign mem_data_in    = injValid ? injData :
                            (pipeV[3] ? (pipeA[3] ^ 16'hA5A5) : 16'h0000);

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h (step %0d)",
                     tag, obs, exp, stepNo);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Everything an idle arbiter should drive: all zero.
    task automatic checkIdle(input string tag);
        checkOutput({tag, ".strobes"},
                    32'({mem_en, mem_wr, i_fill_data_en, d_fill_data_en,
                         i_fill_tag_en, d_fill_tag_en, d_wr_ack, busy}),
                    32'h0);
        checkOutput({tag, ".mem_addr"}, 32'(mem_addr), 32'h0);
        checkOutput({tag, ".mem_data_out"}, 32'(mem_data_out), 32'h0);
        checkOutput({tag, ".fill_data"}, 32'(fill_data), 32'h0);
        checkOutput({tag, ".fill_addr"}, 32'(fill_addr), 32'h0);
    endtask

    // Checks cycles t+1..t+13 of a fill accepted in the current cycle t.
    // Issues at t+1..t+8, data at t+5..t+12, tag write at t+12, idle at t+13.
    // Optionally raises a store request during the fill.
    task automatic applyStimulus(input logic isD, input logic [15:0] blk,
                                 input logic raiseWr);
        logic        expIssue;
        logic        expFill;
        logic [15:0] expAddr;
        logic [15:0] expFillAddr;
        logic [15:0] expFillData;
        for (int k = 1; k <= 13; k++) begin
            nextCycle();
            if (k == 1) begin
                if (isD) d_miss = 1'b0;
                else     i_miss = 1'b0;
                if (raiseWr) d_wr_req = 1'b1;
            end
            @(negedge clk);
            stepNo      = k;
            expIssue    = (k <= 8);
            expAddr     = expIssue ? (blk + 16'(2 * (k - 1))) : 16'h0000;
            expFill     = (k >= 5) && (k <= 12);
            expFillAddr = expFill ? (blk + 16'(2 * (k - 5))) : 16'h0000;
            expFillData = expFill ? (expFillAddr ^ 16'hA5A5) : 16'h0000;
            checkOutput("fill.mem_en", 32'(mem_en), 32'(expIssue));
            checkOutput("fill.mem_wr", 32'(mem_wr), 32'h0);
            checkOutput("fill.mem_addr", 32'(mem_addr), 32'(expAddr));
            checkOutput("fill.mem_data_out", 32'(mem_data_out), 32'h0);
            checkOutput("fill.fill_addr", 32'(fill_addr), 32'(expFillAddr));
            checkOutput("fill.fill_data", 32'(fill_data), 32'(expFillData));
            checkOutput("fill.tgt_data_en",
                        32'(isD ? d_fill_data_en : i_fill_data_en), 32'(expFill));
            checkOutput("fill.tgt_tag_en",
                        32'(isD ? d_fill_tag_en : i_fill_tag_en), 32'(k == 12));
            checkOutput("fill.other_strobes",
                        32'(isD ? {i_fill_data_en, i_fill_tag_en}
                                : {d_fill_data_en, d_fill_tag_en}), 32'h0);
            checkOutput("fill.d_wr_ack", 32'(d_wr_ack), 32'h0);
            checkOutput("fill.busy", 32'(busy), 32'(k <= 12));
        end
    endtask

    initial begin
        rst       = 1'b1;
        i_miss    = 1'b0;
        i_addr    = 16'h0000;
        d_miss    = 1'b0;
        d_addr    = 16'h0000;
        d_wr_req  = 1'b0;
        d_wr_data = 16'h0000;

        // Reset: outputs all zero in the cycle after reset is sampled.
        nextCycle();
        nextCycle();
        rst = 1'b0;
        @(negedge clk);
        stepNo = 0;
        checkIdle("reset");

        // Single I-cache miss at 0x1234 fills block 0x1230.
        i_miss = 1'b1;
        i_addr = 16'h1234;
        applyStimulus(1'b0, 16'h1230, 1'b0);

        // D and I miss together: D first, then I accepted at t+13.
        d_miss = 1'b1;
        d_addr = 16'h5678;
        i_miss = 1'b1;
        i_addr = 16'h9ABC;
        applyStimulus(1'b1, 16'h5670, 1'b0);
        applyStimulus(1'b0, 16'h9AB0, 1'b0);

        // Store, D miss and I miss together: write first, then D, then I.
        d_wr_req  = 1'b1;
        d_miss    = 1'b1;
        i_miss    = 1'b1;
        d_addr    = 16'h4442;
        d_wr_data = 16'hCAFE;
        i_addr    = 16'h0BC9;
        nextCycle();
        @(negedge clk);
        stepNo = 1;
        checkOutput("write.flags", 32'({mem_en, mem_wr, d_wr_ack, busy}), 32'hF);
        checkOutput("write.mem_addr", 32'(mem_addr), 32'h4442);
        checkOutput("write.mem_data_out", 32'(mem_data_out), 32'hCAFE);
        d_wr_req = 1'b0;
        nextCycle();
        @(negedge clk);
        stepNo = 2;
        checkOutput("write.back_idle", 32'({busy, d_wr_ack, mem_en}), 32'h0);
        applyStimulus(1'b1, 16'h4440, 1'b0);
        applyStimulus(1'b0, 16'h0BC0, 1'b0);

        // Store raised during an I fill waits until the fill completes.
        i_miss    = 1'b1;
        i_addr    = 16'h2000;
        d_addr    = 16'h3006;
        d_wr_data = 16'h1357;
        applyStimulus(1'b0, 16'h2000, 1'b1);
        nextCycle();
        @(negedge clk);
        stepNo = 14;
        checkOutput("heldwr.flags", 32'({mem_en, mem_wr, d_wr_ack, busy}), 32'hF);
        checkOutput("heldwr.mem_addr", 32'(mem_addr), 32'h3006);
        checkOutput("heldwr.mem_data_out", 32'(mem_data_out), 32'h1357);
        d_wr_req = 1'b0;
        nextCycle();
        @(negedge clk);
        stepNo = 15;
        checkIdle("heldwr.after");

        // Reset at t+7 of a fill: in-flight data afterwards is ignored.
        i_miss = 1'b1;
        i_addr = 16'h7776;
        for (int k = 1; k <= 12; k++) begin
            nextCycle();
            if (k == 1) i_miss = 1'b0;
            rst = (k == 7);
            @(negedge clk);
            stepNo = k;
            if (k >= 8) checkIdle("rstfill");
        end
        i_miss = 1'b1;
        applyStimulus(1'b0, 16'h7770, 1'b0);

        // Stray valid pulse in IDLE is ignored.
        nextCycle();
        injValid = 1'b1;
        injData  = 16'hBEEF;
        @(negedge clk);
        stepNo = 1;
        checkIdle("strayvalid");
        nextCycle();
        injValid = 1'b0;
        @(negedge clk);
        stepNo = 2;
        checkIdle("strayvalid.after");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checkCount, failCount);
        $finish;
    end

endmodule
